// File: rtl/fir_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_seq_ctrl_if
// Description : Sample, config and datapath-facing signals of the FIR sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_seq_ctrl_if #(
    parameter int COEF_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              cfg_start;
    logic              cfg_valid;
    logic [COEF_W-1:0] cfg_data;
    logic              cfg_ready;
    logic              cfg_busy;
    logic              coef_ok;
    logic              fir_load_c;
    logic [COEF_W-1:0] fir_coef;
    logic [7:0]        fir_data_in;
    logic [14:0]       fir_data_out;
    logic              out_valid;
    logic [14:0]       out_data;

    // Controller side
    modport slave (
        input  in_valid, in_data, cfg_start, cfg_valid, cfg_data, fir_data_out,
        output in_ready, cfg_ready, cfg_busy, coef_ok, fir_load_c, fir_coef,
               fir_data_in, out_valid, out_data
    );

    // System / datapath side
    modport master (
        output in_valid, in_data, cfg_start, cfg_valid, cfg_data, fir_data_out,
        input  in_ready, cfg_ready, cfg_busy, coef_ok, fir_load_c, fir_coef,
               fir_data_in, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_seq_ctrl
// Description : Sequencer for the 25-tap FIR datapath: sample flow, drain and
//               coefficient reload, result valid tagging.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_seq_ctrl #(
    parameter int TAPS    = 25,
    parameter int COEF_W  = 16,
    parameter int FIR_LAT = 2,
    parameter int CNT_W   = 5
) (
    input  logic          clk,
    input  logic          reset,
    fir_seq_ctrl_if.slave bus
);
    localparam int                 c_drain_w    = (FIR_LAT > 1) ? $clog2(FIR_LAT) : 1;
    localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(FIR_LAT - 1);
    localparam logic [CNT_W-1:0]   c_coef_last  = CNT_W'(TAPS - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_drain_w-1:0]  r_drain_cnt, w_drain_cnt_nxt;
    logic [CNT_W-1:0]      r_coef_cnt, w_coef_cnt_nxt;
    logic                  r_coef_ok, w_coef_ok_nxt;
    logic [FIR_LAT-1:0]    r_vpipe;
    logic                  w_in_ready;
    logic                  w_cfg_ready;
    logic                  w_cfg_busy;
    logic                  w_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_drain_cnt <= '0;
            r_coef_cnt  <= '0;
            r_coef_ok   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_coef_cnt  <= w_coef_cnt_nxt;
            r_coef_ok   <= w_coef_ok_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_coef_cnt_nxt  = r_coef_cnt;
        w_coef_ok_nxt   = r_coef_ok;
        w_in_ready      = 1'b0;
        w_cfg_ready     = 1'b0;
        w_cfg_busy      = 1'b0;
        case (r_state)
            S_RUN: begin
                w_in_ready = 1'b1;
                if (bus.cfg_start) begin
                    w_state_nxt     = S_DRAIN;
                    w_drain_cnt_nxt = '0;
                end
            end
            S_DRAIN: begin
                // Wait out the datapath latency so no result is still in flight.
                w_cfg_busy = 1'b1;
                if (r_drain_cnt == c_drain_last) begin
                    w_state_nxt    = S_LOAD;
                    w_coef_cnt_nxt = '0;
                    w_coef_ok_nxt  = 1'b0;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + 1'b1;
                end
            end
            S_LOAD: begin
                w_cfg_busy  = 1'b1;
                w_cfg_ready = 1'b1;
                if (bus.cfg_valid) begin
                    w_coef_cnt_nxt = r_coef_cnt + 1'b1;
                    if (r_coef_cnt == c_coef_last) begin
                        w_coef_ok_nxt = 1'b1;
                        w_state_nxt   = S_RUN;
                    end
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    assign w_accept = bus.in_valid & w_in_ready;

    // Non-accepted cycles feed zeros, so the sample line sees zero-insertion.
    generate
        if (FIR_LAT == 1) begin : g_vpipe_one
            always_ff @(posedge clk) begin
                if (reset) r_vpipe <= '0;
                else       r_vpipe <= w_accept;
            end
        end else begin : g_vpipe_multi
            always_ff @(posedge clk) begin
                if (reset) r_vpipe <= '0;
                else       r_vpipe <= {r_vpipe[FIR_LAT-2:0], w_accept};
            end
        end
    endgenerate

    assign bus.in_ready    = w_in_ready;
    assign bus.cfg_ready   = w_cfg_ready;
    assign bus.cfg_busy    = w_cfg_busy;
    assign bus.coef_ok     = r_coef_ok;
    assign bus.fir_load_c  = (r_state == S_LOAD) & bus.cfg_valid;
    assign bus.fir_coef    = bus.cfg_data;
    assign bus.fir_data_in = w_accept ? bus.in_data : 8'h00;
    assign bus.out_valid   = r_vpipe[FIR_LAT-1];
    assign bus.out_data    = bus.fir_data_out;

endmodule
`default_nettype wire

// File: tb/tb_fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_seq_ctrl
// Description : Scoreboard bench for fir_seq_ctrl with a behavioural 25-tap datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_seq_ctrl;
    localparam int c_taps = 25;
    localparam int c_lat  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fir_seq_ctrl_if #(.COEF_W(16)) bus ();

    fir_seq_ctrl #(
        .TAPS   (c_taps),
        .COEF_W (16),
        .FIR_LAT(c_lat),
        .CNT_W  (5)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Datapath model: load_c shifts the coefficient chain, otherwise the sample line shifts.
    logic signed [15:0] r_dp_c [c_taps];
    logic signed [7:0]  r_dp_x [c_taps];
    logic [14:0]        r_dp_y;
    int                 w_dp_sum;

    always_comb begin
        w_dp_sum = 0;
        for (int i = 0; i < c_taps; i++) w_dp_sum += int'(r_dp_c[i]) * int'(r_dp_x[i]);
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_taps; i++) begin
                r_dp_c[i] <= '0;
                r_dp_x[i] <= '0;
            end
            r_dp_y <= '0;
        end else begin
            if (bus.fir_load_c) begin
                r_dp_c[0] <= bus.fir_coef;
                for (int i = 1; i < c_taps; i++) r_dp_c[i] <= r_dp_c[i-1];
            end else begin
                r_dp_x[0] <= bus.fir_data_in;
                for (int i = 1; i < c_taps; i++) r_dp_x[i] <= r_dp_x[i-1];
            end
            r_dp_y <= w_dp_sum[14:0];
        end
    end
    assign bus.fir_data_out = r_dp_y;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];
    exp_t m_e;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("out_valid_unexpected", 32'd1, 32'd0);
            end else begin
                m_e = sb_q.pop_front();
                check("out_cycle", cyc, m_e.cyc);
                check("out_data", {17'd0, bus.out_data}, m_e.val);
            end
        end
    end

    int wds [c_taps];   // words in write order
    int cref[c_taps];   // expected coefficient per tap
    int samp[64];

    function automatic logic [31:0] conv_exp(input int n);
        int acc;
        acc = 0;
        for (int j = 0; j < c_taps; j++)
            if (n - j >= 0) acc += cref[j] * samp[n - j];
        return {17'd0, acc[14:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit chk_ok0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_in_ready", bus.in_ready, 1);
            check("idle_busy", bus.cfg_busy, 0);
            check("idle_out_valid", bus.out_valid, 0);
            check("idle_load_c", bus.fir_load_c, 0);
            check("idle_data_in", bus.fir_data_in, 0);
            if (chk_ok0) check("idle_coef_ok", bus.coef_ok, 0);
            tick();
        end
    endtask

    task automatic reload(input bit stall, input bit with_sample, input int abort_after);
        int idx = 0, drain = 0, loads = 0, phase = 0, guard = 0;
        logic [31:0] e7;
        e7 = (cref[0] * 7) & 32'h7fff;
        bus.cfg_start = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 16'(wds[0]);
        if (with_sample) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'd7;
        end
        @(negedge clk);
        check("start_in_ready", bus.in_ready, 1);
        check("start_load_c", bus.fir_load_c, 0);
        if (with_sample && bus.in_ready) sb_q.push_back('{cyc: cyc + c_lat, val: e7});
        tick();
        bus.cfg_start = 1'b0;
        bus.in_data   = 8'd9;
        while (idx < c_taps && guard < 200) begin
            bus.cfg_valid = stall ? (phase % 2 == 0) : 1'b1;
            bus.cfg_data  = 16'(wds[idx]);
            @(negedge clk);
            if (bus.fir_load_c) loads++;
            check("busy_in_ready", bus.in_ready, 0);
            check("busy_flag", bus.cfg_busy, 1);
            if (!bus.cfg_ready) begin
                drain++;
                check("drain_load_c", bus.fir_load_c, 0);
            end else begin
                phase++;
                check("load_coef_ok", bus.coef_ok, 0);
                if (bus.cfg_valid) begin
                    check("load_c", bus.fir_load_c, 1);
                    check("load_coef", bus.fir_coef, 32'(wds[idx]) & 32'hffff);
                    idx++;
                end else begin
                    check("gap_load_c", bus.fir_load_c, 0);
                    check("gap_data_in", bus.fir_data_in, 0);
                end
            end
            tick();
            guard++;
            if (abort_after > 0 && idx == abort_after) break;
        end
        bus.cfg_valid = 1'b0;
        bus.in_valid  = 1'b0;
        if (abort_after > 0) begin
            check("abort_words", idx, abort_after);
            return;
        end
        check("reload_words", idx, c_taps);
        check("drain_cycles", drain, c_lat);
        check("load_pulses", loads, c_taps);
        for (int j = 0; j < c_taps; j++) cref[c_taps - 1 - j] = wds[j];
        @(negedge clk);
        check("post_coef_ok", bus.coef_ok, 1);
        check("post_in_ready", bus.in_ready, 1);
        check("post_busy", bus.cfg_busy, 0);
        tick();
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(samp[i]);
            @(negedge clk);
            check("burst_in_ready", bus.in_ready, 1);
            sb_q.push_back('{cyc: cyc + c_lat, val: conv_exp(i)});
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (c_lat + 3) tick();
        check("sb_drained", sb_q.size(), 0);
    endtask

    task automatic set_impulse();
        foreach (samp[i]) samp[i] = 0;
        samp[0] = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 16'd0;
        foreach (cref[j]) cref[j] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_coef_ok", bus.coef_ok, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.cfg_busy, 0);
        tick();
        reset = 1'b0;
        idle(10, 1'b1);

        // Coefficients 1..25, then a unit impulse
        for (int j = 0; j < c_taps; j++) wds[j] = j + 1;
        reload(1'b0, 1'b0, 0);
        idle(30, 1'b0);
        set_impulse();
        burst(26);

        // cfg_start together with a sample
        reload(1'b0, 1'b1, 0);
        idle(30, 1'b0);

        // Stalled reload with large signed words, then random samples
        for (int j = 0; j < c_taps; j++) wds[j] = ((j * 7919) % 20011) * 3 - 30000;
        reload(1'b1, 1'b0, 0);
        idle(30, 1'b0);
        foreach (samp[i]) samp[i] = int'($urandom_range(0, 255)) - 128;
        samp[0] = -128;
        samp[1] = 127;
        burst(40);

        // Reset part-way through a reload, then a full reload
        for (int j = 0; j < c_taps; j++) wds[j] = (c_taps - j) * 3 - 40;
        reload(1'b0, 1'b0, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.cfg_busy, 0);
        check("abort_coef_ok", bus.coef_ok, 0);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_out_valid", bus.out_valid, 0);
        tick();
        reload(1'b0, 1'b0, 0);
        idle(30, 1'b0);
        set_impulse();
        burst(26);

        check("final_sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
